pong_uart_cmd_decoder: RTL and testbench
========================================

// Module: pong_uart_cmd_decoder
// PURPOSE
//  Consumes bytes from the UART receiver and turns keyboard commands into PONG control signals.
//  Outputs: per-player paddle up/down levels held for a fixed time, a game-start pulse and a pause toggle.
//  Decodes single ASCII keys and the VT100 arrow-key escape sequences (ESC '[' 'A'/'B') sent by a terminal.
//  Sits between the UART receiver and the game/paddle logic.
// PARAMETERS
//  c_HOLD_CYCLES  2500000  cycles a paddle output stays high after one key byte (100 ms @ 25 MHz); >=2
//  c_ESC_TIMEOUT  25000    max cycles between bytes of an escape sequence before it is abandoned; >=2
// PORTS
//  i_CLK         in   1  system clock
//  i_RST_N       in   1  reset, asynchronous, active-low
//  i_RX_DATA     in   8  received byte; valid only when i_RX_DV=1
//  i_RX_DV       in   1  one-cycle strobe from the UART receiver; back-to-back strobes allowed
//  o_P1_UP       out  1  player 1 paddle up (level)
//  o_P1_DN       out  1  player 1 paddle down (level)
//  o_P2_UP       out  1  player 2 paddle up (level)
//  o_P2_DN       out  1  player 2 paddle down (level)
//  o_START       out  1  one-cycle pulse: start/serve
//  o_PAUSE       out  1  pause level, toggled by 'p'/'P'
//  o_BAD_CMD     out  1  one-cycle pulse: byte not recognised in IDLE
// BEHAVIOUR
//  - One clock, i_CLK. Reset is asynchronous and active-low (i_RST_N).
//  - Reset, asserted at any time including mid-sequence:
//    - all outputs 0, FSM to IDLE, hold and timeout counters 0
//    - a byte strobed during reset is lost
//  - All outputs are registered: a byte strobed at cycle N affects the outputs from cycle N+1.
//  - IDLE byte map:
//    - 0x77/0x57 w/W -> P1 up; 0x73/0x53 s/S -> P1 down
//    - 0x69/0x49 i/I -> P2 up; 0x6B/0x4B k/K -> P2 down
//    - 0x20 space -> o_START pulse; 0x70/0x50 p/P -> toggle o_PAUSE
//    - 0x0D, 0x0A -> ignored, no error
//    - 0x1B -> go to ESC
//    - any other byte -> o_BAD_CMD pulse
//  - FSM states, one-hot: IDLE, ESC, CSI.
//    - ESC + 0x5B -> CSI.
//    - ESC + any other byte -> IDLE, and that byte is decoded as an IDLE byte in the same cycle
//      (so ESC ESC stays in ESC).
//    - CSI + 0x41 'A' -> P2 up, IDLE; 0x42 'B' -> P2 down, IDLE; 0x43/0x44 -> IDLE, ignored.
//    - CSI + any other byte -> IDLE, discarded, no o_BAD_CMD.
//    - ESC/CSI timeout: counter clears on entry and on each byte. It counts otherwise.
//      At c_ESC_TIMEOUT-1 the FSM returns to IDLE silently.
//    - A byte in the same cycle as the timeout wins: it is decoded in the current state.
//  - Hold timer (one per player):
//    - A direction command loads count = c_HOLD_CYCLES and sets dir; output = (count!=0) & dir.
//    - count decrements each cycle down to 0.
//    - A new command reloads the count; the latest direction wins, so UP and DN are never both high.
//    - A load in the same cycle as expiry: the load wins, with no low gap.
//    - Counter width is $clog2(c_HOLD_CYCLES+1) and must not wrap.
//  - o_PAUSE gates nothing inside this block; paddle outputs still act while paused.
// STRUCTURE
//  - Shared package/include: key-code localparams (K_W, K_S, K_I, K_K, K_SPACE, K_P, K_ESC, K_LBRACKET,
//    K_ARROW_UP, K_ARROW_DN) and the FSM state encodings.
//  - One sub-module, pong_hold_timer (params c_HOLD_CYCLES):
//    - in: i_LOAD_UP, i_LOAD_DN (mutually exclusive)
//    - out: o_UP, o_DN
//    - instantiated twice, one per player.
// TESTING (bench: c_HOLD_CYCLES=16, c_ESC_TIMEOUT=8, bytes 2+ cycles apart unless stated)
//  - Reset mid-sequence: strobe 0x1B, 0x5B, then pulse i_RST_N low -> all outputs 0; next 0x41 gives
//    o_BAD_CMD, no P2 motion.
//  - 'w' at cycle N -> o_P1_UP high cycles N+1..N+16, low at N+17; second 'w' at N+10 -> high through N+26.
//  - 'w' then 's' 5 cycles later -> o_P1_UP drops and o_P1_DN rises the same cycle; never both high.
//  - Strobes 0x1B,0x5B,0x41 back-to-back -> o_P2_UP high for 16 cycles; 0x1B,0x5B,0x42 -> o_P2_DN.
//  - 0x1B, 0x5B, then 8 idle cycles, then 0x41 -> timeout to IDLE, then o_BAD_CMD pulse, no P2 motion;
//    0x1B then 'k' -> o_P2_DN.
//  - 0x20 -> single o_START pulse; 'p','P' -> o_PAUSE 1 then 0; 0x7A -> o_BAD_CMD pulse; 0x0D -> nothing.

Source files
------------

// File: rtl/pong_uart_cmd_decoder_pkg.sv
// Shared key codes, FSM encodings and a key-matching helper for the PONG UART command decoder.
package pong_uart_cmd_decoder_pkg;

    localparam logic [7:0] K_W        = 8'h77;
    localparam logic [7:0] K_S        = 8'h73;
    localparam logic [7:0] K_I        = 8'h69;
    localparam logic [7:0] K_K        = 8'h6B;
    localparam logic [7:0] K_SPACE    = 8'h20;
    localparam logic [7:0] K_P        = 8'h70;
    localparam logic [7:0] K_ESC      = 8'h1B;
    localparam logic [7:0] K_LBRACKET = 8'h5B;
    localparam logic [7:0] K_ARROW_UP = 8'h41;
    localparam logic [7:0] K_ARROW_DN = 8'h42;
    localparam logic [7:0] K_CR       = 8'h0D;
    localparam logic [7:0] K_LF       = 8'h0A;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_ESC  = 3'b010;
    localparam logic [2:0] S_CSI  = 3'b100;

    // Letter keys are stored lower-case; clearing bit 5 gives the upper-case code.
    function automatic logic f_key_match(input logic [7:0] i_b, input logic [7:0] i_k);
        return (i_b == i_k) || (i_b == (i_k & 8'hDF));
    endfunction

endpackage

// File: rtl/pong_uart_cmd_decoder_if.sv
// Bundle between the UART receiver, the command decoder and the game/paddle logic.
// i_RX_DV is a one-cycle strobe qualifying i_RX_DATA; there is no backpressure, every strobe is consumed.
interface pong_uart_cmd_decoder_if;
    logic [7:0] i_RX_DATA;
    logic       i_RX_DV;
    logic       o_P1_UP;
    logic       o_P1_DN;
    logic       o_P2_UP;
    logic       o_P2_DN;
    logic       o_START;
    logic       o_PAUSE;
    logic       o_BAD_CMD;
    logic [2:0] o_STATE;

    modport master (
        output i_RX_DATA, i_RX_DV,
        input  o_P1_UP, o_P1_DN, o_P2_UP, o_P2_DN, o_START, o_PAUSE, o_BAD_CMD, o_STATE
    );

    modport slave (
        input  i_RX_DATA, i_RX_DV,
        output o_P1_UP, o_P1_DN, o_P2_UP, o_P2_DN, o_START, o_PAUSE, o_BAD_CMD, o_STATE
    );
endinterface

// File: rtl/pong_hold_timer.sv
// Per-player paddle hold timer: a load sets the direction and holds the output for c_HOLD_CYCLES cycles.
module pong_hold_timer #(
    parameter int c_HOLD_CYCLES = 2500000
) (
    input  logic i_CLK,
    input  logic i_RST_N,
    input  logic i_LOAD_UP,
    input  logic i_LOAD_DN,
    output logic o_UP,
    output logic o_DN
);
    localparam int               W    = $clog2(c_HOLD_CYCLES + 1);
    localparam logic [W-1:0]     HOLD = W'(c_HOLD_CYCLES);

    logic [W-1:0] r_count;
    logic         r_dir;
    logic         w_active;

    // A load beats expiry, so back-to-back commands never leave a low gap.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_count <= '0;
            r_dir   <= 1'b0;
        end else if (i_LOAD_UP || i_LOAD_DN) begin
            r_count <= HOLD;
            r_dir   <= i_LOAD_UP;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign w_active = (r_count != '0);
    assign o_UP     = w_active & r_dir;
    assign o_DN     = w_active & ~r_dir;
endmodule

// File: rtl/pong_uart_cmd_decoder.sv
// Turns UART bytes (single keys and VT100 arrow sequences) into PONG paddle, start and pause controls.
module pong_uart_cmd_decoder
    import pong_uart_cmd_decoder_pkg::*;
#(
    parameter int c_HOLD_CYCLES = 2500000,
    parameter int c_ESC_TIMEOUT = 25000
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_N,
    pong_uart_cmd_decoder_if.slave   bus
);
    localparam int               TW      = $clog2(c_ESC_TIMEOUT);
    localparam logic [TW-1:0]    TO_LAST = TW'(c_ESC_TIMEOUT - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [TW-1:0] r_esc_cnt;
    logic          r_start;
    logic          r_pause;
    logic          r_bad;
    logic          w_dv;
    logic [7:0]    w_data;
    logic          w_idle_byte;
    logic          w_p1_up, w_p1_dn, w_p2_up, w_p2_dn;
    logic          w_start, w_pause_tgl, w_bad;
    logic          w_p1_up_q, w_p1_dn_q, w_p2_up_q, w_p2_dn_q;

    assign w_dv   = bus.i_RX_DV;
    assign w_data = bus.i_RX_DATA;

    always_comb begin
        w_next      = r_state;
        w_idle_byte = 1'b0;
        w_p1_up     = 1'b0;
        w_p1_dn     = 1'b0;
        w_p2_up     = 1'b0;
        w_p2_dn     = 1'b0;
        w_start     = 1'b0;
        w_pause_tgl = 1'b0;
        w_bad       = 1'b0;
        if (w_dv) begin
            case (r_state)
                S_CSI: begin
                    w_next  = S_IDLE;
                    w_p2_up = (w_data == K_ARROW_UP);
                    w_p2_dn = (w_data == K_ARROW_DN);
                end
                S_ESC: begin
                    if (w_data == K_LBRACKET) w_next = S_CSI;
                    else                      w_idle_byte = 1'b1;
                end
                default: w_idle_byte = 1'b1;
            endcase
        end else if ((r_state != S_IDLE) && (r_esc_cnt == TO_LAST)) begin
            w_next = S_IDLE;
        end

        // A byte abandoning an ESC prefix is decoded exactly as in IDLE, so ESC ESC stays in ESC.
        if (w_idle_byte) begin
            w_next = S_IDLE;
            if      (f_key_match(w_data, K_W))           w_p1_up     = 1'b1;
            else if (f_key_match(w_data, K_S))           w_p1_dn     = 1'b1;
            else if (f_key_match(w_data, K_I))           w_p2_up     = 1'b1;
            else if (f_key_match(w_data, K_K))           w_p2_dn     = 1'b1;
            else if (w_data == K_SPACE)                  w_start     = 1'b1;
            else if (f_key_match(w_data, K_P))           w_pause_tgl = 1'b1;
            else if (w_data == K_ESC)                    w_next      = S_ESC;
            else if (w_data == K_CR || w_data == K_LF)   w_bad       = 1'b0;
            else                                         w_bad       = 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state   <= S_IDLE;
            r_esc_cnt <= '0;
            r_start   <= 1'b0;
            r_pause   <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_esc_cnt <= (w_dv || (r_state == S_IDLE)) ? '0 : r_esc_cnt + TW'(1);
            r_start   <= w_start;
            r_pause   <= r_pause ^ w_pause_tgl;
            r_bad     <= w_bad;
        end
    end

    pong_hold_timer #(.c_HOLD_CYCLES(c_HOLD_CYCLES)) u_p1_timer (
        .i_CLK     (i_CLK),
        .i_RST_N   (i_RST_N),
        .i_LOAD_UP (w_p1_up),
        .i_LOAD_DN (w_p1_dn),
        .o_UP      (w_p1_up_q),
        .o_DN      (w_p1_dn_q)
    );

    pong_hold_timer #(.c_HOLD_CYCLES(c_HOLD_CYCLES)) u_p2_timer (
        .i_CLK     (i_CLK),
        .i_RST_N   (i_RST_N),
        .i_LOAD_UP (w_p2_up),
        .i_LOAD_DN (w_p2_dn),
        .o_UP      (w_p2_up_q),
        .o_DN      (w_p2_dn_q)
    );

    assign bus.o_P1_UP   = w_p1_up_q;
    assign bus.o_P1_DN   = w_p1_dn_q;
    assign bus.o_P2_UP   = w_p2_up_q;
    assign bus.o_P2_DN   = w_p2_dn_q;
    assign bus.o_START   = r_start;
    assign bus.o_PAUSE   = r_pause;
    assign bus.o_BAD_CMD = r_bad;
    assign bus.o_STATE   = r_state;
endmodule

// File: tb/tb_pong_uart_cmd_decoder.sv
// Bench for pong_uart_cmd_decoder: directed byte scenarios, expected output-change events in a queue.
module tb_pong_uart_cmd_decoder;
  localparam int HOLD = 16;
  localparam int TMO  = 8;

  localparam logic [6:0] V_P1U = 7'b1000000;
  localparam logic [6:0] V_P1D = 7'b0100000;
  localparam logic [6:0] V_P2U = 7'b0010000;
  localparam logic [6:0] V_P2D = 7'b0001000;
  localparam logic [6:0] V_ST  = 7'b0000100;
  localparam logic [6:0] V_PA  = 7'b0000010;
  localparam logic [6:0] V_BAD = 7'b0000001;
  localparam logic [6:0] V_0   = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [22:0] exp_q[$];
  logic [6:0]  prev_vec = 7'b0;
  logic [6:0]  w_vec;
  int   b;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pong_uart_cmd_decoder_if bus_if ();

  pong_uart_cmd_decoder #(
    .c_HOLD_CYCLES(HOLD),
    .c_ESC_TIMEOUT(TMO)
  ) dut (
    .i_CLK  (clk),
    .i_RST_N(rst_n),
    .bus    (bus_if)
  );

  assign w_vec = {bus_if.o_P1_UP, bus_if.o_P1_DN, bus_if.o_P2_UP, bus_if.o_P2_DN,
                  bus_if.o_START, bus_if.o_PAUSE, bus_if.o_BAD_CMD};

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_at(input int c, input logic [7:0] byte_v);
    if (cyc > c) begin
      total++;
      bad++;
      $display("FAIL send_late want_cyc=%0d now_cyc=%0d", c, cyc);
    end
    wait_until(c);
    bus_if.i_RX_DATA = byte_v;
    bus_if.i_RX_DV   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.i_RX_DV   = 1'b0;
  endtask

  task automatic expect_at(input int c, input logic [6:0] v);
    exp_q.push_back({16'(c), v});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [22:0] e;
    if (w_vec !== prev_vec) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, w_vec);
      end else begin
        e = exp_q.pop_front();
        if ({16'(cyc), w_vec} !== e) begin
          bad++;
          $display("FAIL out_event got cyc=%0d vec=%b want cyc=%0d vec=%b",
                   cyc, w_vec, e[22:7], e[6:0]);
        end
      end
      total++;
      if ((w_vec[6] & w_vec[5]) | (w_vec[4] & w_vec[3])) begin
        bad++;
        $display("FAIL up_dn_both cyc=%0d got=%b want no UP&DN pair", cyc, w_vec);
      end
      prev_vec = w_vec;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus_if.i_RX_DATA = 8'h00;
    bus_if.i_RX_DV   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (w_vec !== V_0 || bus_if.o_STATE !== 3'b001) begin
      bad++;
      $display("FAIL reset_state got vec=%b state=%b want vec=0000000 state=001", w_vec, bus_if.o_STATE);
    end
    rst_n = 1'b1;
    wait_until(cyc + 2);

    // reset in the middle of ESC '[' clears outputs, pause and hold counter
    b = cyc + 2;
    expect_at(b + 1, V_P1U);
    expect_at(b + 3, V_P1U | V_PA);
    expect_at(b + 8, V_0);
    expect_at(b + 12, V_BAD);
    expect_at(b + 13, V_0);
    send_at(b, 8'h77);
    send_at(b + 2, 8'h70);
    send_at(b + 4, 8'h1B);
    send_at(b + 6, 8'h5B);
    wait_until(b + 8);
    rst_n = 1'b0;
    #1;
    total++;
    if (w_vec !== V_0) begin
      bad++;
      $display("FAIL reset_mid_seq got=%b want=0000000", w_vec);
    end
    send_at(b + 8, 8'h77);
    rst_n = 1'b1;
    send_at(b + 11, 8'h41);
    wait_until(b + 40);

    // hold length and reload
    b = cyc + 2;
    expect_at(b + 1, V_P1U);
    expect_at(b + 17, V_0);
    expect_at(b + 21, V_P1U);
    expect_at(b + 47, V_0);
    send_at(b, 8'h77);
    send_at(b + 20, 8'h77);
    send_at(b + 30, 8'h77);
    wait_until(b + 55);

    // direction change in one cycle
    b = cyc + 2;
    expect_at(b + 1, V_P1U);
    expect_at(b + 6, V_P1D);
    expect_at(b + 22, V_0);
    send_at(b, 8'h77);
    send_at(b + 5, 8'h73);
    wait_until(b + 30);

    // back-to-back arrow sequences
    b = cyc + 2;
    expect_at(b + 3, V_P2U);
    expect_at(b + 19, V_0);
    expect_at(b + 28, V_P2D);
    expect_at(b + 44, V_0);
    send_at(b, 8'h1B);
    send_at(b + 1, 8'h5B);
    send_at(b + 2, 8'h41);
    send_at(b + 25, 8'h1B);
    send_at(b + 26, 8'h5B);
    send_at(b + 27, 8'h42);
    wait_until(b + 50);

    // escape timeouts, ESC + plain key, ESC ESC, ignored CSI finals
    b = cyc + 2;
    expect_at(b + 12, V_BAD);
    expect_at(b + 13, V_0);
    expect_at(b + 31, V_P2U);
    expect_at(b + 47, V_0);
    expect_at(b + 53, V_P2D);
    expect_at(b + 69, V_0);
    expect_at(b + 79, V_P2U);
    expect_at(b + 95, V_0);
    expect_at(b + 110, V_BAD);
    expect_at(b + 111, V_0);
    expect_at(b + 125, V_BAD);
    expect_at(b + 126, V_0);
    expect_at(b + 135, V_ST);
    expect_at(b + 136, V_0);
    send_at(b, 8'h1B);
    send_at(b + 2, 8'h5B);
    send_at(b + 11, 8'h41);
    send_at(b + 20, 8'h1B);
    send_at(b + 22, 8'h5B);
    send_at(b + 30, 8'h41);
    send_at(b + 50, 8'h1B);
    send_at(b + 52, 8'h6B);
    send_at(b + 75, 8'h1B);
    send_at(b + 76, 8'h1B);
    send_at(b + 77, 8'h5B);
    send_at(b + 78, 8'h41);
    send_at(b + 100, 8'h1B);
    send_at(b + 109, 8'h5B);
    send_at(b + 120, 8'h1B);
    send_at(b + 121, 8'h5B);
    send_at(b + 122, 8'h43);
    send_at(b + 124, 8'h41);
    send_at(b + 130, 8'h1B);
    send_at(b + 131, 8'h5B);
    send_at(b + 132, 8'h31);
    send_at(b + 134, 8'h20);
    wait_until(b + 145);

    // start, pause toggle, bad byte, CR/LF, upper-case keys
    b = cyc + 2;
    expect_at(b + 1, V_ST);
    expect_at(b + 2, V_0);
    expect_at(b + 4, V_PA);
    expect_at(b + 7, V_0);
    expect_at(b + 10, V_BAD);
    expect_at(b + 11, V_0);
    expect_at(b + 16, V_P2U);
    expect_at(b + 17, V_P1D | V_P2U);
    expect_at(b + 32, V_P1D);
    expect_at(b + 33, V_0);
    expect_at(b + 41, V_P1U);
    expect_at(b + 42, V_P1U | V_P2D);
    expect_at(b + 57, V_P2D);
    expect_at(b + 58, V_0);
    send_at(b, 8'h20);
    send_at(b + 3, 8'h70);
    send_at(b + 6, 8'h50);
    send_at(b + 9, 8'h7A);
    send_at(b + 12, 8'h0D);
    send_at(b + 13, 8'h0A);
    send_at(b + 15, 8'h49);
    send_at(b + 16, 8'h53);
    send_at(b + 40, 8'h57);
    send_at(b + 41, 8'h4B);
    wait_until(b + 70);

    // ---------------- final report ----------------
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got_left=%0d want_left=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
